// File: rtl/jtkiwi_shr_arb_if.sv
// Shared-RAM bus between the main CPU, the sub CPU and the arbiter.
// The CPU side (or a bench) uses the master modport, the arbiter the slave.
interface jtkiwi_shr_arb_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          m_cs;
  logic          m_rnw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;
  logic          m_ok;
  logic          s_cs;
  logic          s_rnw;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          s_ok;
  logic          mshramen;
  logic [7:0]    st_dout;

  modport master (
    output m_cs, m_rnw, m_addr, m_din,
    output s_cs, s_rnw, s_addr, s_din,
    output mshramen,
    input  m_dout, m_ok, s_dout, s_ok, st_dout
  );

  modport slave (
    input  m_cs, m_rnw, m_addr, m_din,
    input  s_cs, s_rnw, s_addr, s_din,
    input  mshramen,
    output m_dout, m_ok, s_dout, s_ok, st_dout
  );
endinterface

// File: rtl/jtkiwi_shr_arb.sv
// Two-CPU arbiter for one single-port shared RAM: IDLE/ACC/DONE sequence,
// round robin on conflicts, one-shot ok per request and a contention counter.
module jtkiwi_shr_arb #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  jtkiwi_shr_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        r_state;
  logic          r_own_sub;
  logic          r_rd;
  logic          r_last_sub;
  logic [1:0]    r_armed;
  logic          r_m_ok;
  logic          r_s_ok;
  logic [DW-1:0] r_m_dout;
  logic [DW-1:0] r_s_dout;
  logic [7:0]    r_cnt;
  logic [DW-1:0] r_ram_q;
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  logic [1:0]    w_cs;
  logic [1:0]    w_en;
  logic [1:0]    w_elig;
  logic          w_idle;
  logic          w_both;
  logic          w_gnt;
  logic          w_gnt_sub;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;
  logic          w_rnw;
  logic          w_we;
  logic          w_own_cs;

  // Index 0 is the main CPU, index 1 the sub CPU.
  assign w_cs = {bus.s_cs, bus.m_cs};
  assign w_en = {bus.mshramen, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign w_elig[gi] = w_cs[gi] & r_armed[gi] & w_en[gi];
    end
  endgenerate

  // No grant (hence no RAM write) can happen while reset is held.
  assign w_idle    = (r_state == IDLE) & ~rst;
  assign w_both    = w_elig[0] & w_elig[1];
  assign w_gnt     = w_idle & (w_elig[0] | w_elig[1]);
  assign w_gnt_sub = w_elig[1] & (~w_elig[0] | ~r_last_sub);
  assign w_addr    = w_gnt_sub ? bus.s_addr : bus.m_addr;
  assign w_din     = w_gnt_sub ? bus.s_din  : bus.m_din;
  assign w_rnw     = w_gnt_sub ? bus.s_rnw  : bus.m_rnw;
  assign w_we      = w_gnt & ~w_rnw;
  assign w_own_cs  = r_own_sub ? bus.s_cs : bus.m_cs;

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_din;
    end
    r_ram_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_own_sub  <= 1'b0;
      r_rd       <= 1'b0;
      r_last_sub <= 1'b1;
      r_armed    <= 2'b11;
      r_m_ok     <= 1'b0;
      r_s_ok     <= 1'b0;
      r_m_dout   <= '0;
      r_s_dout   <= '0;
      r_cnt      <= 8'd0;
    end else begin
      r_m_ok <= 1'b0;
      r_s_ok <= 1'b0;
      if (!w_cs[0]) r_armed[0] <= 1'b1;
      if (!w_cs[1]) r_armed[1] <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_both && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_gnt) begin
            r_state   <= ACC;
            r_own_sub <= w_gnt_sub;
            r_rd      <= w_rnw;
            // Round robin only tracks who won the last conflict.
            if (w_both) r_last_sub <= w_gnt_sub;
          end
        end
        ACC: begin
          if (r_rd) begin
            if (r_own_sub) r_s_dout <= r_ram_q;
            else           r_m_dout <= r_ram_q;
          end
          if (w_own_cs) begin
            if (r_own_sub) r_s_ok <= 1'b1;
            else           r_m_ok <= 1'b1;
            r_armed[r_own_sub] <= 1'b0;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_ok    = r_m_ok;
  assign bus.s_ok    = r_s_ok;
  assign bus.m_dout  = r_m_dout;
  assign bus.s_dout  = r_s_dout;
  assign bus.st_dout = r_cnt;

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed and random checks of the shared-RAM arbiter against a
// schedule-based model (grant time + fixed latencies, plain memory array).
module tb_jtkiwi_shr_arb;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtkiwi_shr_arb_if #(.AW(AW), .DW(DW)) bus();
  jtkiwi_shr_arb #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic obs_m_ok, obs_s_ok;
  int m_ok_cyc = -100, s_ok_cyc = -100;
  int m_ok_n = 0, s_ok_n = 0;

  // Model state: memory, busy window, one pending access, expected outputs.
  logic [7:0] mm [int];
  int   free_at;
  bit   armed_m, armed_s, last_sub;
  bit   pv, pp_sub, prd;
  int   pg;
  logic [7:0] pdata;
  logic [7:0] e_m_dout, e_s_dout, e_cnt;
  bit   e_m_ok, e_s_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_at  = cyc + 1;
    armed_m  = 1'b1;
    armed_s  = 1'b1;
    last_sub = 1'b1;
    pv       = 1'b0;
    e_m_ok   = 1'b0;
    e_s_ok   = 1'b0;
    e_m_dout = 8'h00;
    e_s_dout = 8'h00;
    e_cnt    = 8'h00;
  endtask

  task automatic model_step();
    bit ok_m, ok_s, em, es, gs, rnw;
    logic [AW-1:0] a;
    ok_m = 1'b0;
    ok_s = 1'b0;
    if (pv && cyc == pg + 1) begin
      if (prd) begin
        if (pp_sub) e_s_dout = pdata;
        else        e_m_dout = pdata;
      end
      if (pp_sub && bus.s_cs)  ok_s = 1'b1;
      if (!pp_sub && bus.m_cs) ok_m = 1'b1;
      pv = 1'b0;
    end
    if (cyc >= free_at) begin
      em = bus.m_cs && armed_m;
      es = bus.s_cs && armed_s && bus.mshramen;
      if (em && es) begin
        if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
        gs = !last_sub;
        last_sub = gs;
      end else begin
        gs = es;
      end
      if (em || es) begin
        pv = 1'b1; pg = cyc; pp_sub = gs; free_at = cyc + 3;
        a   = gs ? bus.s_addr : bus.m_addr;
        rnw = gs ? bus.s_rnw  : bus.m_rnw;
        prd = rnw;
        if (!rnw) mm[int'(a)] = gs ? bus.s_din : bus.m_din;
        else      pdata = mm.exists(int'(a)) ? mm[int'(a)] : 8'h00;
      end
    end
    armed_m = !bus.m_cs ? 1'b1 : (ok_m ? 1'b0 : armed_m);
    armed_s = !bus.s_cs ? 1'b1 : (ok_s ? 1'b0 : armed_s);
    e_m_ok = ok_m;
    e_s_ok = ok_s;
  endtask

  // One clock cycle: sample/compare at negedge, advance model, return after posedge.
  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    obs_m_ok = bus.m_ok;
    obs_s_ok = bus.s_ok;
    check("m_ok",    {31'd0, bus.m_ok}, {31'd0, e_m_ok});
    check("s_ok",    {31'd0, bus.s_ok}, {31'd0, e_s_ok});
    check("m_dout",  {24'd0, bus.m_dout}, {24'd0, e_m_dout});
    check("s_dout",  {24'd0, bus.s_dout}, {24'd0, e_s_dout});
    check("st_dout", {24'd0, bus.st_dout}, {24'd0, e_cnt});
    if (obs_m_ok) begin
      m_ok_cyc = cyc; m_ok_n++;
      $display("cyc %0d: main ok dout=%02h st=%0d", cyc, bus.m_dout, bus.st_dout);
    end
    if (obs_s_ok) begin
      s_ok_cyc = cyc; s_ok_n++;
      $display("cyc %0d: sub ok dout=%02h st=%0d", cyc, bus.s_dout, bus.st_dout);
    end
    if (!rst) model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input bit sub, input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sub ? obs_s_ok : obs_m_ok) && n < maxc);
    check(sub ? "wait_s_ok" : "wait_m_ok", {31'd0, (sub ? obs_s_ok : obs_m_ok)}, 32'd1);
  endtask

  task automatic main_acc(input bit rnw, input logic [AW-1:0] a, input logic [7:0] d);
    int t0;
    bus.m_cs = 1'b1; bus.m_rnw = rnw; bus.m_addr = a; bus.m_din = d;
    t0 = cyc;
    wait_ok(1'b0, 10);
    bus.m_cs = 1'b0;
    tick();
    check("main_latency", m_ok_cyc - t0, 32'd2);
  endtask

  task automatic serve_both(input int maxc);
    int n;
    n = 0;
    while ((bus.m_cs || bus.s_cs) && n < maxc) begin
      tick();
      n++;
      if (obs_m_ok) bus.m_cs = 1'b0;
      if (obs_s_ok) bus.s_cs = 1'b0;
    end
    check("serve_done", {30'd0, bus.m_cs, bus.s_cs}, 32'd0);
    bus.m_cs = 1'b0;
    bus.s_cs = 1'b0;
    tick();
  endtask

  initial begin
    int t0, n0;
    bus.m_cs = 0; bus.m_rnw = 1; bus.m_addr = '0; bus.m_din = '0;
    bus.s_cs = 0; bus.s_rnw = 1; bus.s_addr = '0; bus.s_din = '0;
    bus.mshramen = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check("rst_st_dout", {24'd0, bus.st_dout}, 32'd0);
    rst = 1'b0;
    tick();

    // Known contents for the random phase.
    for (int i = 0; i < 16; i++) main_acc(1'b0, AW'(i), 8'($urandom));

    // Write then read back.
    main_acc(1'b0, 13'h1234, 8'hA5);
    main_acc(1'b1, 13'h1234, 8'h00);
    check("rd_1234", {24'd0, bus.m_dout}, 32'hA5);

    // First conflict: main wins.
    bus.m_cs = 1; bus.m_rnw = 1; bus.m_addr = 13'h1234;
    bus.s_cs = 1; bus.s_rnw = 1; bus.s_addr = 13'h1234;
    t0 = cyc;
    serve_both(20);
    check("c1_m_lat", m_ok_cyc - t0, 32'd2);
    check("c1_s_lat", s_ok_cyc - t0, 32'd5);
    check("c1_st", {24'd0, bus.st_dout}, 32'd1);
    check("c1_s_dout", {24'd0, bus.s_dout}, 32'hA5);

    // Second conflict: sub wins.
    bus.m_cs = 1; bus.m_rnw = 1; bus.m_addr = 13'h0002;
    bus.s_cs = 1; bus.s_rnw = 1; bus.s_addr = 13'h1234;
    t0 = cyc;
    serve_both(20);
    check("c2_s_lat", s_ok_cyc - t0, 32'd2);
    check("c2_m_lat", m_ok_cyc - t0, 32'd5);
    check("c2_st", {24'd0, bus.st_dout}, 32'd2);

    // Sub held off while mshramen is low; main keeps working.
    bus.mshramen = 1'b0;
    bus.s_cs = 1; bus.s_rnw = 1; bus.s_addr = 13'h0003;
    n0 = s_ok_n;
    tick(); tick();
    main_acc(1'b0, 13'h0005, 8'h77);
    main_acc(1'b1, 13'h0005, 8'h00);
    check("hold_m_dout", {24'd0, bus.m_dout}, 32'h77);
    tick(); tick();
    check("hold_no_s_ok", s_ok_n - n0, 32'd0);
    bus.mshramen = 1'b1;
    t0 = cyc;
    wait_ok(1'b1, 10);
    bus.s_cs = 1'b0;
    tick();
    check("enable_s_lat", s_ok_cyc - t0, 32'd2);

    // Held cs gives a single ok until it is dropped and reasserted.
    bus.m_cs = 1; bus.m_rnw = 1; bus.m_addr = 13'h1234;
    wait_ok(1'b0, 10);
    n0 = m_ok_n;
    repeat (6) tick();
    check("held_no_2nd_ok", m_ok_n - n0, 32'd0);
    bus.m_cs = 1'b0;
    tick();
    bus.m_cs = 1'b1;
    t0 = cyc;
    wait_ok(1'b0, 10);
    bus.m_cs = 1'b0;
    tick();
    check("rearm_lat", m_ok_cyc - t0, 32'd2);

    // Reset during the ACC cycle of a sub write.
    bus.s_cs = 1; bus.s_rnw = 0; bus.s_addr = 13'h0010; bus.s_din = 8'h3C;
    n0 = s_ok_n;
    tick();
    rst = 1'b1;
    #1;
    check("arst_m_ok",   {31'd0, bus.m_ok}, 32'd0);
    check("arst_s_ok",   {31'd0, bus.s_ok}, 32'd0);
    check("arst_m_dout", {24'd0, bus.m_dout}, 32'd0);
    check("arst_s_dout", {24'd0, bus.s_dout}, 32'd0);
    check("arst_st",     {24'd0, bus.st_dout}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    bus.s_cs = 1'b0;
    tick(); tick();
    check("rst_no_s_ok", s_ok_n - n0, 32'd0);
    main_acc(1'b1, 13'h0010, 8'h00);
    check("rst_kept_wr", {24'd0, bus.m_dout}, 32'h3C);

    // Random traffic on the prewritten addresses.
    for (int i = 0; i < 500; i++) begin
      if (!bus.m_cs) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.m_cs = 1; bus.m_rnw = 1'($urandom); bus.m_addr = AW'($urandom_range(0, 15));
          bus.m_din = 8'($urandom);
        end
      end else if ((obs_m_ok && $urandom_range(0, 3) != 0) || $urandom_range(0, 19) == 0) begin
        bus.m_cs = 0;
      end
      if (!bus.s_cs) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.s_cs = 1; bus.s_rnw = 1'($urandom); bus.s_addr = AW'($urandom_range(0, 15));
          bus.s_din = 8'($urandom);
        end
      end else if ((obs_s_ok && $urandom_range(0, 3) != 0) || $urandom_range(0, 19) == 0) begin
        bus.s_cs = 0;
      end
      if ($urandom_range(0, 15) == 0) bus.mshramen = ~bus.mshramen;
      tick();
    end
    bus.m_cs = 0;
    bus.s_cs = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
